// File: rtl/favm_burst_monitor.sv
// favm_burst_monitor: passive Avalon-MM protocol monitor with burst support.
// Tracks outstanding read beats and write responses, and records protocol
// violations as sticky error flags plus the index of the first error seen.
module favm_burst_monitor #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 14,
  parameter int unsigned BW        = 4,
  parameter int unsigned LGDEPTH   = 8,
  parameter int unsigned MAX_OUTST = 200,
  parameter int unsigned MAX_STALL = 0,
  parameter int unsigned MAX_WAIT  = 0,
  parameter int unsigned LGWAIT    = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_av_read,
  input  logic               i_av_write,
  input  logic [AW-1:0]      i_av_address,
  input  logic [DW-1:0]      i_av_writedata,
  input  logic [DW/8-1:0]    i_av_byteenable,
  input  logic [BW-1:0]      i_av_burstcount,
  input  logic               i_av_waitrequest,
  input  logic               i_av_readdatavalid,
  input  logic               i_av_writeresponsevalid,
  output logic [LGDEPTH-1:0] o_rd_outstanding,
  output logic [LGDEPTH-1:0] o_wr_outstanding,
  output logic [10:0]        o_err,
  output logic [3:0]         o_first_err
);

  typedef enum logic {ST_IDLE, ST_BURST} burst_state_t;

  localparam logic [LGDEPTH:0] CNT_MAX = {1'b0, {LGDEPTH{1'b1}}};
  localparam logic [LGDEPTH:0] CNT_ONE = {{LGDEPTH{1'b0}}, 1'b1};

  burst_state_t        state_q, state_d;
  logic [AW-1:0]       burst_addr_q, burst_addr_d;
  logic [BW-1:0]       burst_len_q, burst_len_d;
  logic [BW-1:0]       beat_cnt_q, beat_cnt_d;
  logic                wr_done;

  logic [LGDEPTH-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [LGDEPTH:0]    rd_sum, wr_sum;
  logic [LGWAIT-1:0]   stall_q, stall_d, wait_q, wait_d;

  logic                hold_valid_q, hold_valid_d;
  logic                hold_read_q, hold_read_d, hold_write_q, hold_write_d;
  logic [AW-1:0]       hold_addr_q, hold_addr_d;
  logic [DW-1:0]       hold_data_q, hold_data_d;
  logic [DW/8-1:0]     hold_be_q, hold_be_d;
  logic [BW-1:0]       hold_bc_q, hold_bc_d;

  logic [10:0]         err_q, err_d, new_err;
  logic [3:0]          first_err_q, first_err_d, lowest_idx;

  logic req, req_stall, rd_accept, wr_accept, busy, resp;

  assign req       = i_av_read || i_av_write;
  assign req_stall = req && i_av_waitrequest;
  assign rd_accept = i_av_read && !i_av_waitrequest;
  assign wr_accept = i_av_write && !i_av_waitrequest;
  assign busy      = (rd_cnt_q != '0) || (wr_cnt_q != '0);
  assign resp      = i_av_readdatavalid || i_av_writeresponsevalid;

  // Write burst tracker: latch the burst header on the first beat and count beats to the last
  always_comb begin
    state_d      = state_q;
    burst_addr_d = burst_addr_q;
    burst_len_d  = burst_len_q;
    beat_cnt_d   = beat_cnt_q;
    wr_done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_accept) begin
          if (i_av_burstcount == BW'(1)) begin
            wr_done = 1'b1;
          end else if (i_av_burstcount > BW'(1)) begin
            state_d      = ST_BURST;
            burst_addr_d = i_av_address;
            burst_len_d  = i_av_burstcount;
            beat_cnt_d   = BW'(1);
          end
        end
      end
      ST_BURST: begin
        if (wr_accept) begin
          if (beat_cnt_q + BW'(1) == burst_len_q) begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
            wr_done    = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outstanding counters plus stall and wait timers, all saturating in both directions
  always_comb begin
    rd_sum = {1'b0, rd_cnt_q} + (rd_accept ? (LGDEPTH+1)'(i_av_burstcount) : '0);
    if (i_av_readdatavalid && rd_sum != '0) rd_sum = rd_sum - CNT_ONE;
    rd_cnt_d = (rd_sum > CNT_MAX) ? CNT_MAX[LGDEPTH-1:0] : rd_sum[LGDEPTH-1:0];

    wr_sum = {1'b0, wr_cnt_q} + (wr_done ? CNT_ONE : '0);
    if (i_av_writeresponsevalid && wr_sum != '0) wr_sum = wr_sum - CNT_ONE;
    wr_cnt_d = (wr_sum > CNT_MAX) ? CNT_MAX[LGDEPTH-1:0] : wr_sum[LGDEPTH-1:0];

    stall_d = '0;
    if (req_stall) stall_d = (stall_q == '1) ? stall_q : stall_q + LGWAIT'(1);

    wait_d = '0;
    if (busy && !resp) wait_d = (wait_q == '1) ? wait_q : wait_q + LGWAIT'(1);
  end

  // Snapshot of a stalled request so the next cycle can verify it was held unchanged
  always_comb begin
    hold_valid_d = req_stall;
    hold_read_d  = i_av_read;
    hold_write_d = i_av_write;
    hold_addr_d  = i_av_address;
    hold_data_d  = i_av_writedata;
    hold_be_d    = i_av_byteenable;
    hold_bc_d    = i_av_burstcount;
  end

  // Detect this cycle's violations and merge them into the sticky flags and first-error index
  always_comb begin
    new_err     = '0;
    new_err[0]  = i_av_read && i_av_write;
    new_err[1]  = hold_valid_q &&
                  ((i_av_read != hold_read_q) || (i_av_write != hold_write_q) ||
                   (i_av_address != hold_addr_q) || (i_av_burstcount != hold_bc_q) ||
                   (i_av_byteenable != hold_be_q) ||
                   (hold_write_q && (i_av_writedata != hold_data_q)));
    new_err[2]  = (i_av_read || (i_av_write && state_q == ST_IDLE)) && (i_av_burstcount == '0);
    new_err[3]  = i_av_write && (i_av_byteenable == '0);
    new_err[4]  = i_av_readdatavalid && (rd_cnt_q == '0) && !rd_accept;
    new_err[5]  = i_av_writeresponsevalid && (wr_cnt_q == '0) && !wr_done;
    new_err[6]  = i_av_readdatavalid && i_av_writeresponsevalid;
    new_err[7]  = (32'(rd_cnt_q) + 32'(wr_cnt_q)) > MAX_OUTST;
    new_err[8]  = (MAX_STALL != 0) && req_stall && (32'(stall_d) >= MAX_STALL);
    new_err[9]  = (MAX_WAIT != 0) && (wait_d != '0) && (32'(wait_d) >= MAX_WAIT);
    new_err[10] = (state_q == ST_BURST) &&
                  (i_av_read || (i_av_write && ((i_av_address != burst_addr_q) ||
                                                (i_av_burstcount != burst_len_q))));

    lowest_idx = 4'hf;
    for (int i = 10; i >= 0; i--) begin
      if (new_err[i]) lowest_idx = 4'(i);
    end

    err_d       = (i_clear ? '0 : err_q) | new_err;
    first_err_d = i_clear ? 4'hf : first_err_q;
    if (first_err_d == 4'hf && new_err != '0) first_err_d = lowest_idx;
  end

  // State register; reset discards any in-flight burst and all tracking
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      burst_addr_q <= '0;
      burst_len_q  <= '0;
      beat_cnt_q   <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      stall_q      <= '0;
      wait_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_read_q  <= 1'b0;
      hold_write_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      hold_be_q    <= '0;
      hold_bc_q    <= '0;
      err_q        <= '0;
      first_err_q  <= 4'hf;
    end else begin
      state_q      <= state_d;
      burst_addr_q <= burst_addr_d;
      burst_len_q  <= burst_len_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      stall_q      <= stall_d;
      wait_q       <= wait_d;
      hold_valid_q <= hold_valid_d;
      hold_read_q  <= hold_read_d;
      hold_write_q <= hold_write_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      hold_be_q    <= hold_be_d;
      hold_bc_q    <= hold_bc_d;
      err_q        <= err_d;
      first_err_q  <= first_err_d;
    end
  end

  assign o_rd_outstanding = rd_cnt_q;
  assign o_wr_outstanding = wr_cnt_q;
  assign o_err            = err_q;
  assign o_first_err      = first_err_q;

endmodule

// File: tb/tb_favm_burst_monitor.sv
// tb_favm_burst_monitor: directed vectors with hand-computed expected counts and error flags.
module tb_favm_burst_monitor;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic        avRead, avWrite, avWait, avRdv, avWrv;
  logic [13:0] avAddr;
  logic [31:0] avData;
  logic [3:0]  avBe, avBc;
  logic [7:0]  rdOut, wrOut;
  logic [10:0] err;
  logic [3:0]  firstErr;

  int checkCount = 0;
  int errCount   = 0;

  favm_burst_monitor #(
    .DW(32), .AW(14), .BW(4), .LGDEPTH(8), .MAX_OUTST(20),
    .MAX_STALL(4), .MAX_WAIT(8), .LGWAIT(8)
  ) dut (
    .i_clk                   (clk),
    .i_reset                 (reset),
    .i_clear                 (clear),
    .i_av_read               (avRead),
    .i_av_write              (avWrite),
    .i_av_address            (avAddr),
    .i_av_writedata          (avData),
    .i_av_byteenable         (avBe),
    .i_av_burstcount         (avBc),
    .i_av_waitrequest        (avWait),
    .i_av_readdatavalid      (avRdv),
    .i_av_writeresponsevalid (avWrv),
    .o_rd_outstanding        (rdOut),
    .o_wr_outstanding        (wrOut),
    .o_err                   (err),
    .o_first_err             (firstErr)
  );

  always #5 clk = ~clk;

  // Drive one cycle of bus activity, then step to just after the capturing edge
  task automatic applyStimulus(input logic rd, input logic wr, input logic [13:0] addr,
                               input logic [3:0] bc, input logic [3:0] be, input logic wt,
                               input logic rdv, input logic wrv, input logic clr);
    avRead  = rd;
    avWrite = wr;
    avAddr  = addr;
    avBc    = bc;
    avBe    = be;
    avWait  = wt;
    avRdv   = rdv;
    avWrv   = wrv;
    clear   = clr;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expectation and tally the result
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the full visible state of the monitor
  task automatic checkState(input string tag, input int rdExp, input int wrExp,
                            input logic [10:0] errExp, input logic [3:0] firstExp);
    checkOutput({tag, ".rd"},    32'(rdOut),    32'(rdExp));
    checkOutput({tag, ".wr"},    32'(wrOut),    32'(wrExp));
    checkOutput({tag, ".err"},   32'(err),      32'(errExp));
    checkOutput({tag, ".first"}, 32'(firstErr), 32'(firstExp));
  endtask

  // Directed scenario sequence
  initial begin
    avData = 32'hA5A5_1234;
    reset  = 1'b1;
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 0, 0, 0);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 0, 0, 0);
    checkState("reset", 0, 0, 11'h000, 4'hf);
    reset = 1'b0;
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 0, 0, 0);

    // Read burst of 4 then four returned beats
    applyStimulus(1, 0, 14'h10, 4'd4, 4'hf, 0, 0, 0, 0);
    checkState("rd4.acc", 4, 0, 11'h000, 4'hf);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 0, 0, 0);
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 1, 0, 0);
      checkOutput("rd4.beat", 32'(rdOut), 32'(i));
    end
    checkState("rd4.end", 0, 0, 11'h000, 4'hf);

    // Three-beat write burst with a stall on beat 2
    applyStimulus(0, 1, 14'h20, 4'd3, 4'hf, 0, 0, 0, 0);
    checkState("wr3.b1", 0, 0, 11'h000, 4'hf);
    applyStimulus(0, 1, 14'h20, 4'd3, 4'hf, 1, 0, 0, 0);
    applyStimulus(0, 1, 14'h20, 4'd3, 4'hf, 0, 0, 0, 0);
    checkState("wr3.b2", 0, 0, 11'h000, 4'hf);
    applyStimulus(0, 1, 14'h20, 4'd3, 4'hf, 0, 0, 0, 0);
    checkState("wr3.b3", 0, 1, 11'h000, 4'hf);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 0, 1, 0);
    checkState("wr3.resp", 0, 0, 11'h000, 4'hf);

    // Address changed while stalled, then clear on acceptance
    applyStimulus(1, 0, 14'h30, 4'd1, 4'hf, 1, 0, 0, 0);
    applyStimulus(1, 0, 14'h34, 4'd1, 4'hf, 1, 0, 0, 0);
    checkState("hold", 0, 0, 11'h002, 4'h1);
    applyStimulus(1, 0, 14'h34, 4'd1, 4'hf, 0, 0, 0, 1);
    checkState("hold.clr", 1, 0, 11'h000, 4'hf);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 1, 0, 0);
    checkState("hold.rdv", 0, 0, 11'h000, 4'hf);

    // Unexpected readdatavalid
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 1, 0, 0);
    checkState("rdv0", 0, 0, 11'h010, 4'h4);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 0, 0, 1);

    // Stall timeout at exactly four stalled cycles
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 14'h40, 4'd2, 4'hf, 1, 0, 0, 0);
    checkState("stall3", 0, 0, 11'h000, 4'hf);
    applyStimulus(1, 0, 14'h40, 4'd2, 4'hf, 1, 0, 0, 0);
    checkState("stall4", 0, 0, 11'h100, 4'h8);
    applyStimulus(1, 0, 14'h40, 4'd2, 4'hf, 0, 0, 0, 1);
    checkState("stall.acc", 2, 0, 11'h000, 4'hf);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 1, 0, 0);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 1, 0, 0);
    checkState("stall.drain", 0, 0, 11'h000, 4'hf);

    // Reset in the middle of a 4-beat write burst, then a clean single write
    applyStimulus(0, 1, 14'h50, 4'd4, 4'hf, 0, 0, 0, 0);
    applyStimulus(0, 1, 14'h50, 4'd4, 4'hf, 0, 0, 0, 0);
    checkState("wr4.b2", 0, 0, 11'h000, 4'hf);
    reset = 1'b1;
    applyStimulus(0, 1, 14'h50, 4'd4, 4'hf, 0, 0, 0, 0);
    reset = 1'b0;
    checkState("wr4.rst", 0, 0, 11'h000, 4'hf);
    applyStimulus(0, 1, 14'h60, 4'd1, 4'hf, 0, 0, 0, 0);
    checkState("wr1", 0, 1, 11'h000, 4'hf);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 0, 1, 0);
    checkState("wr1.resp", 0, 0, 11'h000, 4'hf);

    // Wait timeout: one read outstanding with no response
    applyStimulus(1, 0, 14'h70, 4'd1, 4'hf, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 0, 0, 0);
    checkState("wait7", 1, 0, 11'h000, 4'hf);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 0, 0, 0);
    checkState("wait8", 1, 0, 11'h200, 4'h9);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 1, 0, 1);
    checkState("wait.clr", 0, 0, 11'h000, 4'hf);

    // Read and write together with zero byteenable: lowest index wins
    applyStimulus(1, 1, 14'h80, 4'd1, 4'h0, 0, 0, 0, 0);
    checkState("rdwr", 1, 1, 11'h009, 4'h0);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 1, 0, 0);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 0, 1, 0);
    checkState("rdwr.drain", 0, 0, 11'h009, 4'h0);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 0, 0, 1);

    // Both response strobes with nothing pending
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 1, 1, 0);
    checkState("bothresp", 0, 0, 11'h070, 4'h4);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 0, 0, 1);

    // Zero burstcount on read
    applyStimulus(1, 0, 14'h90, 4'd0, 4'hf, 0, 0, 0, 0);
    checkState("bc0", 0, 0, 11'h004, 4'h2);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 0, 0, 1);

    // Address changes within a burst
    applyStimulus(0, 1, 14'hA0, 4'd2, 4'hf, 0, 0, 0, 0);
    applyStimulus(0, 1, 14'hA4, 4'd2, 4'hf, 0, 0, 0, 0);
    checkState("burstaddr", 0, 1, 11'h400, 4'ha);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 0, 1, 1);
    checkState("burstaddr.clr", 0, 0, 11'h000, 4'hf);

    // Outstanding exceeds the limit of 20
    applyStimulus(1, 0, 14'hB0, 4'd15, 4'hf, 0, 0, 0, 0);
    applyStimulus(1, 0, 14'hC0, 4'd7, 4'hf, 0, 0, 0, 0);
    checkOutput("outst.rd", 32'(rdOut), 32'd22);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 1, 0, 0);
    checkState("outst", 21, 0, 11'h080, 4'h7);
    for (int i = 0; i < 21; i++) applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 1, 0, 0);
    applyStimulus(0, 0, 14'h0, 4'd1, 4'hf, 0, 0, 0, 1);
    checkState("outst.clr", 0, 0, 11'h000, 4'hf);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
